// File: rtl/qk_dot_accum_pkg.sv
// Shared types and constants for the QK dot-product accumulator.
// Q_WIDTH(I, F) gives the total width of a signed Q(I, F) value: sign + I + F.
`ifndef Q_WIDTH
`define Q_WIDTH(i, f) ((i) + (f) + 1)
`endif

package qk_dot_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } dot_state_t;

    localparam int DOT_D_DEFAULT = 64;

endpackage

// File: rtl/qk_dot_accum_add.sv
// Signed accumulator adder: acc + opd with overflow flag.
// Saturation is built only when AURA_DOT_SAT_EN is defined; otherwise the sum wraps.
module q_sat_add #(
    parameter int W_ACC = 22,
    parameter int W_OPD = 16
) (
    input  logic signed [W_ACC-1:0] acc,
    input  logic signed [W_OPD-1:0] opd,
    output logic signed [W_ACC-1:0] sum,
    output logic                    ovf
);

    // One guard bit above the wider operand holds the exact sum.
    localparam int W_SUM = ((W_ACC > W_OPD) ? W_ACC : W_OPD) + 1;

    logic signed [W_SUM-1:0] sum_x;

    assign sum_x = W_SUM'(acc) + W_SUM'(opd);

`ifdef AURA_DOT_SAT_EN
    localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

    logic [W_SUM-W_ACC:0] hi_bits;

    function automatic logic signed [W_ACC-1:0] sat_clamp(input logic signed [W_SUM-1:0] x,
                                                          input logic is_ovf);
        if (!is_ovf) begin
            return W_ACC'(x);
        end
        return x[W_SUM-1] ? ACC_MIN : ACC_MAX;
    endfunction

    // In range only when every bit from the accumulator sign bit upward agrees.
    assign hi_bits = sum_x[W_SUM-1:W_ACC-1];
    assign ovf     = !((&hi_bits) || !(|hi_bits));
    assign sum     = sat_clamp(sum_x, ovf);
`else
    assign sum = W_ACC'(sum_x);
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/qk_dot_accum.sv
// Streaming signed Q/K dot-product accumulator with registered valid/ready score output.
// Optional saturation on accumulator overflow: define AURA_DOT_SAT_EN.
module qk_dot_accum
    import qk_dot_accum_pkg::*;
#(
    parameter int IN_I  = 3,
    parameter int IN_F  = 4,
    parameter int D     = DOT_D_DEFAULT,
    parameter int ACC_I = 2*IN_I + 1 + $clog2(D),
    localparam int W_IN   = `Q_WIDTH(IN_I, IN_F),
    localparam int W_PROD = `Q_WIDTH(2*IN_I+1, 2*IN_F),
    localparam int W_ACC  = `Q_WIDTH(ACC_I, 2*IN_F)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_IN-1:0]  q_elem,
    input  logic signed [W_IN-1:0]  k_elem,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_ACC-1:0] score,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(D);

    dot_state_t               state_q, state_d;
    logic signed [W_ACC-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;

    logic signed [W_PROD-1:0] prod;
    logic signed [W_ACC-1:0]  sum;
    logic                     add_ovf;

    assign prod = W_PROD'(q_elem) * W_PROD'(k_elem);

    q_sat_add #(
        .W_ACC (W_ACC),
        .W_OPD (W_PROD)
    ) u_add (
        .acc (acc_q),
        .opd (prod),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q == CNT_W'(D-1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // Score is held until the consumer takes it; then a fresh vector begins.
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign score     = acc_q;
    assign overflow  = ovf_q;

endmodule
